// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, PC-stage FSM states, opcodes.
// Imported by the fetch PC stage and its interface.
package mips_pkg;

  localparam int PC_LENGTH_DEF       = 11;
  localparam int CYCLE_COUNT_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_HALTED    = 2'd3
  } pc_state_e;

  localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/program_counter_stage_if.sv
// Control/redirect inputs and fetch outputs of the PC stage.
// master = debug unit + ID stage side, slave = PC stage.
interface program_counter_stage_if
  import mips_pkg::*;
#(
  parameter int PC_LENGTH       = PC_LENGTH_DEF,
  parameter int CYCLE_COUNT_LEN = CYCLE_COUNT_LEN_DEF
);

  logic                       i_enable;
  logic                       i_step_mode;
  logic                       i_step;
  logic                       i_stall;
  logic                       i_branch_taken;
  logic [PC_LENGTH-1:0]       i_branch_target;
  logic                       i_jump;
  logic [PC_LENGTH-1:0]       i_jump_target;
  logic                       i_halt_detected;
  logic [PC_LENGTH-1:0]       o_pc;
  logic [PC_LENGTH-1:0]       o_pc_plus_one;
  logic                       o_valid;
  logic                       o_halted;
  logic [CYCLE_COUNT_LEN-1:0] o_cycle_count;

  modport master (
    output i_enable, i_step_mode, i_step,
    output i_stall, i_branch_taken,
    output i_branch_target, i_jump,
    output i_jump_target, i_halt_detected,
    input  o_pc, o_pc_plus_one, o_valid,
    input  o_halted, o_cycle_count
  );

  modport slave (
    input  i_enable, i_step_mode, i_step,
    input  i_stall, i_branch_taken,
    input  i_branch_target, i_jump,
    input  i_jump_target, i_halt_detected,
    output o_pc, o_pc_plus_one, o_valid,
    output o_halted, o_cycle_count
  );

endinterface

// File: rtl/edge_detector.sv
// Rising-edge pulse on a level input, using a registered copy of the
// previous sample. Pulse is high for the first cycle the level is seen high.
module edge_detector (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/program_counter_stage.sv
// Instruction-fetch PC stage: run/step/halt FSM, next-PC redirect mux,
// saturating count of advancing cycles.
module program_counter_stage
  import mips_pkg::*;
#(
  parameter int PC_LENGTH       = PC_LENGTH_DEF,
  parameter int CYCLE_COUNT_LEN = CYCLE_COUNT_LEN_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  program_counter_stage_if.slave  bus
);

  localparam logic [PC_LENGTH-1:0] PC_ONE =
    {{(PC_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_COUNT_LEN-1:0] CNT_ONE =
    {{(CYCLE_COUNT_LEN-1){1'b0}}, 1'b1};

  pc_state_e                  r_state;
  logic [PC_LENGTH-1:0]       r_pc;
  logic                       r_valid;
  logic                       r_halted;
  logic [CYCLE_COUNT_LEN-1:0] r_cnt;

  logic                 w_step_edge;
  logic                 w_may;
  logic                 w_adv;
  logic                 w_halt_now;
  logic                 w_cnt_max;
  logic [PC_LENGTH-1:0] w_pc_plus_one;
  logic [PC_LENGTH-1:0] w_next_pc;

  edge_detector u_step_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sig   (bus.i_step),
    .o_pulse (w_step_edge)
  );

  assign w_pc_plus_one = r_pc + PC_ONE;

  // The step edge is spent in the cycle it appears, even if stalled.
  assign w_may = (r_state == ST_RUN) |
                 ((r_state == ST_STEP_WAIT) & w_step_edge);
  assign w_halt_now = w_may & bus.i_halt_detected;
  assign w_adv = w_may & ~bus.i_stall &
                 ~bus.i_halt_detected;
  assign w_cnt_max = &r_cnt;

  always_comb begin
    w_next_pc = w_pc_plus_one;
    priority case (1'b1)
      bus.i_branch_taken: w_next_pc = bus.i_branch_target;
      bus.i_jump:         w_next_pc = bus.i_jump_target;
      default:            w_next_pc = w_pc_plus_one;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= w_adv;
      if (w_adv) begin
        r_pc <= w_next_pc;
      end
      if (w_adv & ~w_cnt_max) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_enable) begin
            r_state <= bus.i_step_mode ?
                       ST_STEP_WAIT : ST_RUN;
          end
        end
        ST_RUN, ST_STEP_WAIT: begin
          if (w_halt_now) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (!bus.i_enable) begin
            r_state <= ST_IDLE;
          end else if (bus.i_step_mode) begin
            r_state <= ST_STEP_WAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  assign bus.o_pc          = r_pc;
  assign bus.o_pc_plus_one = w_pc_plus_one;
  assign bus.o_valid       = r_valid;
  assign bus.o_halted      = r_halted;
  assign bus.o_cycle_count = r_cnt;

endmodule

// File: tb/tb_program_counter_stage.sv
// Bench for the PC stage: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_program_counter_stage;

  localparam int     PCW     = 11;
  localparam int     PC_MOD  = 2048;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   cmp_en;

  program_counter_stage_if #(.PC_LENGTH(PCW)) bus ();

  program_counter_stage #(.PC_LENGTH(PCW)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the stage.
  int     m_mode;
  int     m_pc;
  bit     m_valid;
  bit     m_halted;
  longint m_cnt;
  bit     m_prev_step;
  bit     m_edge;
  bit     m_may;
  bit     m_adv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode      = M_IDLE;
      m_pc        = 0;
      m_valid     = 1'b0;
      m_halted    = 1'b0;
      m_cnt       = 0;
      m_prev_step = 1'b0;
    end else begin
      m_edge      = bus.i_step && !m_prev_step;
      m_prev_step = bus.i_step;
      m_may = (m_mode == M_RUN) ||
              (m_mode == M_STEP && m_edge);
      m_adv = m_may && !bus.i_stall &&
              !bus.i_halt_detected;
      m_valid = m_adv;
      if (m_adv) begin
        if (bus.i_branch_taken)
          m_pc = int'(bus.i_branch_target);
        else if (bus.i_jump)
          m_pc = int'(bus.i_jump_target);
        else
          m_pc = (m_pc + 1) % PC_MOD;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      if (m_mode == M_HALT) begin
        m_mode = M_HALT;
      end else if (m_may && bus.i_halt_detected) begin
        m_mode   = M_HALT;
        m_halted = 1'b1;
      end else if (m_mode == M_IDLE) begin
        if (bus.i_enable)
          m_mode = bus.i_step_mode ? M_STEP : M_RUN;
      end else if (!bus.i_enable) begin
        m_mode = M_IDLE;
      end else begin
        m_mode = bus.i_step_mode ? M_STEP : M_RUN;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("pc", 64'(bus.o_pc), 64'(m_pc));
      chk("pc_plus_one", 64'(bus.o_pc_plus_one),
          64'((m_pc + 1) % PC_MOD));
      chk("valid", 64'(bus.o_valid), 64'(m_valid));
      chk("halted", 64'(bus.o_halted), 64'(m_halted));
      chk("cycle_count", 64'(bus.o_cycle_count),
          64'(m_cnt));
    end
  end

  task automatic clear_inputs();
    bus.i_enable        = 1'b0;
    bus.i_step_mode     = 1'b0;
    bus.i_step          = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = '0;
    bus.i_jump          = 1'b0;
    bus.i_jump_target   = '0;
    bus.i_halt_detected = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    clear_inputs();
    cyc(2);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("rst_pc", 64'(bus.o_pc), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_halted", 64'(bus.o_halted), 64'd0);
    chk("rst_cnt", 64'(bus.o_cycle_count), 64'd0);

    // Run from reset: first enabled cycle only leaves IDLE.
    bus.i_enable = 1'b1;
    cyc(1);
    chk("run_pc0", 64'(bus.o_pc), 64'd0);
    chk("run_valid0", 64'(bus.o_valid), 64'd0);
    cyc(1);
    chk("run_pc1", 64'(bus.o_pc), 64'd1);
    chk("run_valid1", 64'(bus.o_valid), 64'd1);
    cyc(4);
    chk("run_pc5", 64'(bus.o_pc), 64'd5);
    chk("run_cnt5", 64'(bus.o_cycle_count), 64'd5);

    // Stall two cycles at pc 3.
    bus.i_jump = 1'b1;
    bus.i_jump_target = 11'd3;
    cyc(1);
    bus.i_jump = 1'b0;
    chk("jmp_pc3", 64'(bus.o_pc), 64'd3);
    bus.i_stall = 1'b1;
    cyc(1);
    chk("stall_pc", 64'(bus.o_pc), 64'd3);
    chk("stall_valid", 64'(bus.o_valid), 64'd0);
    cyc(1);
    chk("stall_cnt", 64'(bus.o_cycle_count), 64'd6);
    bus.i_stall = 1'b0;
    cyc(1);
    chk("resume_pc", 64'(bus.o_pc), 64'd4);
    chk("resume_cnt", 64'(bus.o_cycle_count), 64'd7);

    // Branch beats jump at pc 7.
    bus.i_jump = 1'b1;
    bus.i_jump_target = 11'd7;
    cyc(1);
    chk("jmp_pc7", 64'(bus.o_pc), 64'd7);
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 11'h040;
    bus.i_jump_target   = 11'h010;
    cyc(1);
    bus.i_branch_taken = 1'b0;
    bus.i_jump = 1'b0;
    chk("br_prio", 64'(bus.o_pc), 64'h40);
    cyc(1);
    chk("br_seq", 64'(bus.o_pc), 64'h41);

    // Wrap at the top of the address space.
    bus.i_jump = 1'b1;
    bus.i_jump_target = 11'h7FF;
    cyc(1);
    bus.i_jump = 1'b0;
    chk("top_pc", 64'(bus.o_pc), 64'h7FF);
    chk("top_plus1", 64'(bus.o_pc_plus_one), 64'h0);
    cyc(1);
    chk("wrap_pc", 64'(bus.o_pc), 64'h0);

    // Enable drop: current cycle still advances.
    bus.i_enable = 1'b0;
    cyc(1);
    chk("endrop_pc", 64'(bus.o_pc), 64'd1);
    cyc(1);
    chk("idle_pc", 64'(bus.o_pc), 64'd1);
    chk("idle_valid", 64'(bus.o_valid), 64'd0);

    // Single step with a held level.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    bus.i_enable    = 1'b1;
    bus.i_step_mode = 1'b1;
    cyc(1);
    chk("step_pc0", 64'(bus.o_pc), 64'd0);
    bus.i_step = 1'b1;
    cyc(10);
    chk("step_held", 64'(bus.o_pc), 64'd1);
    chk("step_cnt", 64'(bus.o_cycle_count), 64'd1);
    bus.i_step = 1'b0;
    cyc(2);
    bus.i_step = 1'b1;
    cyc(3);
    chk("step_again", 64'(bus.o_pc), 64'd2);
    bus.i_step = 1'b0;

    // Halt beats stall and redirect; absorbing.
    bus.i_step_mode = 1'b0;
    cyc(1);
    bus.i_jump = 1'b1;
    bus.i_jump_target = 11'd9;
    cyc(1);
    bus.i_jump = 1'b0;
    chk("halt_at9", 64'(bus.o_pc), 64'd9);
    bus.i_halt_detected = 1'b1;
    bus.i_stall = 1'b1;
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 11'h055;
    cyc(1);
    clear_inputs();
    bus.i_enable = 1'b1;
    chk("halted", 64'(bus.o_halted), 64'd1);
    chk("halt_pc", 64'(bus.o_pc), 64'd9);
    chk("halt_valid", 64'(bus.o_valid), 64'd0);
    cyc(5);
    chk("halt_hold", 64'(bus.o_pc), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 64'(bus.o_pc), 64'd0);
    chk("arst_halted", 64'(bus.o_halted), 64'd0);
    cyc(1);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.i_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0)
        bus.i_step_mode = ~bus.i_step_mode;
      bus.i_step = 1'($urandom_range(0, 1));
      bus.i_stall = ($urandom_range(0, 6) == 0);
      bus.i_branch_taken = ($urandom_range(0, 7) == 0);
      bus.i_jump = ($urandom_range(0, 7) == 0);
      bus.i_branch_target = 11'($urandom_range(0, 2047));
      bus.i_jump_target = 11'($urandom_range(0, 2047));
      bus.i_halt_detected = ($urandom_range(0, 149) == 0);
      if (m_mode == M_HALT && $urandom_range(0, 7) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
